// File: rtl/prog_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_down_counter
// Description : Loadable N-bit down counter with one-shot / auto-reload modes
//               and a single-cycle registered terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_reload_val;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_q          <= c_zero;
            r_reload_val <= c_zero;
            r_tc         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_q          <= w_q_nxt;
            r_reload_val <= w_reload_nxt;
            r_tc         <= w_tc_nxt;
            r_busy       <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    // Load outranks everything; otherwise only RUN with en high moves the count.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload_val;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_q_nxt      = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = (load_val != c_zero) ? S_RUN : S_IDLE;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (en) begin
                        if (r_q > c_one) begin
                            w_q_nxt = r_q - c_one;
                        end else if (r_q == c_one) begin
                            w_tc_nxt = 1'b1;
                            if (reload) begin
                                w_q_nxt = r_reload_val;
                            end else begin
                                w_q_nxt     = c_zero;
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_down_counter
// Description : Self-checking bench: behavioural model, per-cycle compare,
//               directed literal checks and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_down_counter;

    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    prog_down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .reload   (reload),
        .q        (q),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 = idle, 1 = counting, 2 = expired.
    int m_q, m_rl, m_mode;
    bit m_tc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= 0; m_rl <= 0; m_mode <= 0; m_tc <= 1'b0;
        end else if (load) begin
            m_q    <= int'(load_val);
            m_rl   <= int'(load_val);
            m_mode <= (load_val == 0) ? 0 : 1;
            m_tc   <= 1'b0;
        end else begin
            m_tc <= 1'b0;
            if (m_mode == 1 && en) begin
                if (m_q - 1 == 0) begin
                    m_tc <= 1'b1;
                    if (reload) m_q <= m_rl;
                    else begin
                        m_q <= 0; m_mode <= 2;
                    end
                end else begin
                    m_q <= m_q - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    bit cmp_on = 1'b1;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_q",    (^q === 1'bx) ? -1 : int'(q), m_q);
            chk("model_tc",   (tc === 1'bx) ? -1 : int'(tc), int'(m_tc));
            chk("model_busy", (busy === 1'bx) ? -1 : int'(busy), (m_mode == 1) ? 1 : 0);
            chk("model_done", (done === 1'bx) ? -1 : int'(done), (m_mode == 2) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int eq, input int etc, input int ebusy, input int edone);
        chk({name, "_q"}, int'(q), eq);
        chk({name, "_tc"}, int'(tc), etc);
        chk({name, "_busy"}, int'(busy), ebusy);
        chk({name, "_done"}, int'(done), edone);
    endtask

    initial begin
        int exp_ar[9];
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; reload = 1'b0;
        repeat (3) step();
        chk_out("in_reset", 0, 0, 0, 0);
        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("idle_noload", 0, 0, 0, 0);
        end

        // One-shot from 5
        load = 1'b1; load_val = 3'd5; reload = 1'b0; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        chk_out("os_load", 5, 0, 1, 0);
        for (int v = 4; v >= 1; v--) begin
            step();
            chk_out("os_count", v, 0, 1, 0);
        end
        step();
        chk_out("os_term", 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("os_hold", 0, 0, 0, 1);
        end

        // Auto-reload period 3
        load = 1'b1; load_val = 3'd3; reload = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        chk_out("ar_load", 3, 0, 1, 0);
        exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 9; i++) begin
            step();
            chk_out("ar_seq", exp_ar[i], (exp_ar[i] == 3) ? 1 : 0, 1, 0);
        end

        // Enable gating from max value
        load = 1'b1; load_val = 3'd7; reload = 1'b0; en = 1'b0;
        step();
        load = 1'b0;
        chk_out("eg_load", 7, 0, 1, 0);
        en = 1'b1; step(); chk_out("eg_en1", 6, 0, 1, 0);
        en = 1'b0; step(); chk_out("eg_en0", 6, 0, 1, 0);
        en = 1'b1; step(); chk_out("eg_en1b", 5, 0, 1, 0);
        en = 1'b0; step(); chk_out("eg_en0b", 5, 0, 1, 0);
        en = 1'b1;
        for (int v = 4; v >= 1; v--) begin
            step();
            chk_out("eg_run", v, 0, 1, 0);
        end
        step();
        chk_out("eg_term", 0, 1, 0, 1);

        // Load on terminal edge, then zero load
        load = 1'b1; load_val = 3'd2; reload = 1'b0; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        step();
        chk_out("lp_pre", 1, 0, 1, 0);
        load = 1'b1; load_val = 3'd6;
        step();
        chk_out("lp_win", 6, 0, 1, 0);
        load_val = 3'd0;
        step();
        load = 1'b0;
        chk_out("lp_zero", 0, 0, 0, 0);
        step();
        chk_out("lp_zero_hold", 0, 0, 0, 0);

        // Asynchronous reset mid-count
        load = 1'b1; load_val = 3'd6; reload = 1'b1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        step(); step();
        chk_out("ar_pre", 4, 0, 1, 0);
        #2 reset = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("post_rst", 0, 0, 0, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, (1 << W) - 1));
            en       = ($urandom_range(0, 3) != 0);
            reload   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_down_counter.md
Name: prog_down_counter

Overview:
Loadable, synchronous N-bit down counter. It is the counting-direction complement of the 3-bit ripple up counter in the Counters & Registers set. It counts from a loaded value down to zero and flags terminal count. It runs either one-shot (stops at zero) or auto-reload (periodic, divide-by-N), and serves as the timer/divider partner to the up counters.

Parameters:
WIDTH, 3, counter width in bits; legal range 2..16

Ports:
clk       input   1      clock; all state changes on rising edge
reset     input   1      asynchronous, active-low reset (low = reset asserted)
load      input   1      load load_val into counter and reload register; arms counter
load_val  input   WIDTH  start/reload value, unsigned
en        input   1      count enable; decrement only when high in RUN
reload    input   1      1 = auto-reload at terminal count, 0 = one-shot
q         output  WIDTH  current count, registered
tc        output  1      terminal-count pulse, registered, exactly one cycle
busy      output  1      high while in RUN
done      output  1      sticky; high in DONE (one-shot expired) until next load

Behaviour:
- Reset (reset low, asynchronous, independent of clk): q=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. Takes effect immediately mid-count. Counting resumes only after a load following reset release.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE). All outputs are registered; there are no combinational paths from inputs to outputs.
- load high at an edge, in any state, has top priority over en, reload and terminal logic:
  - q <= load_val; reload register <= load_val; tc <= 0.
  - Next state is RUN if load_val != 0, otherwise IDLE.
- IDLE: q holds; en is ignored; tc=0.
- RUN, en low: q holds; tc=0; state unchanged.
- RUN, en high, q > 1: q <= q-1; tc <= 0.
- RUN, en high, q == 1 (terminal edge): tc <= 1 for this single cycle. reload is sampled at this edge:
  - reload=1: q <= reload register value; state stays RUN. Period = reload value cycles of en; with load_val=1, tc is high every enabled cycle.
  - reload=0: q <= 0; state <= DONE.
- DONE: q holds 0; en is ignored; tc=0 after the pulse cycle; done stays high until a load.
- tc is deasserted on every edge without a terminal event, including while en is low.
- Arithmetic: unsigned, modulo 2^WIDTH. The counter never decrements below 0 and never wraps to all-ones.
- Simultaneous load and terminal edge: load wins; tc=0; the new value is loaded.
- Changing reload mid-count has effect only at the next terminal edge.
- Changing load_val without load has no effect.

Test Plan:
- Reset/idle (WIDTH=3): hold reset low, toggle clk; release; run 5 cycles with en=1 and no load -> q=0, tc=0, busy=0, done=0 throughout.
- One-shot: load with load_val=5, reload=0, then en=1 -> q 5,4,3,2,1,0 on successive edges; tc=1 only in the cycle q becomes 0; busy falls and done rises at that edge; q stays 0 for 4 more cycles.
- Auto-reload: load_val=3, reload=1, en=1 for 10 cycles -> q sequence 3,2,1,3,2,1,3,2,1,3; tc pulses at each 1->3 transition (every 3rd cycle); busy stays 1.
- Enable gating and max value: load 7; toggle en 1,0,1,0 -> q 7,6,6,5,5; tc=0; then hold en=1 -> one-shot reaches 0 with a single tc.
- Load priority and zero load: assert load with load_val=6 on the terminal edge of a running count -> q=6, tc=0, state RUN. Load load_val=0 -> state IDLE, busy=0, no tc.
- Reset mid-operation: during RUN at q=4, drive reset low between clock edges -> q=0, busy=0 immediately, before the next edge; after release the counter stays idle until load.
